// File: rtl/col_decoder_3b_plus.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : col_decoder_3b_plus
// Description : Parses 3B+ column-encoder words into pixels and timestamps.
// Revision    : 1.0 - initial release
// ============================================================================
module col_decoder_3b_plus #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pkt_i,
  input  logic        pkt_valid_i,
  output logic [2:0]  pix_o,
  output logic        pix_valid_o,
  output logic        pix_last_o,
  output logic [31:0] ts_o,
  output logic        ts_valid_o,
  output logic        ts_kind_o,
  output logic        ovf_o
);

  localparam int          AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CW         = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] RES_MARKER = 16'h8000;

  typedef enum logic [1:0] {
    NORM   = 2'd0,
    RES_HI = 2'd1,
    RES_LO = 2'd2
  } state_e;

  state_e        state_q;
  logic          expect_ts_q;
  logic [15:0]   ts_hi_q;
  logic [31:0]   ts_q;
  logic          ts_valid_q;
  logic          ts_kind_q;

  logic [2:0]    flush_k;
  logic          is_norm;
  logic          push;
  logic [2:0]    push_cnt;
  logic          alarm;

  logic [17:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [CW-1:0] cnt_q;
  logic          ovf_q;

  logic [14:0]   ent_q;
  logic [14:0]   ent_d;
  logic [2:0]    rem_q;
  logic [2:0]    rem_d;
  logic [2:0]    pix_q;
  logic [2:0]    pix_d;
  logic          pv_q;
  logic          pv_d;
  logic          pl_q;
  logic          pl_d;

  logic          empty;
  logic          full;
  logic          idle;
  logic          pop;
  logic          bypass;
  logic          wr;
  logic          drop;
  logic [17:0]   src;

  // Flush markers are matched longest prefix first.
  always_comb begin
    flush_k = 3'd0;
    if (pkt_i[14:3] == 12'hFFE)
      flush_k = 3'd1;
    else if (pkt_i[14:6] == 9'b111111110)
      flush_k = 3'd2;
    else if (pkt_i[14:9] == 6'b111110)
      flush_k = 3'd3;
    else if (pkt_i[14:12] == 3'b110)
      flush_k = 3'd4;
  end

  assign is_norm  = pkt_valid_i && (state_q == NORM);
  assign push     = is_norm && (!pkt_i[15] || (!expect_ts_q && (flush_k != 3'd0)));
  assign push_cnt = pkt_i[15] ? flush_k : 3'd5;
  assign alarm    = is_norm && pkt_i[15] &&
                    (expect_ts_q || ((pkt_i != RES_MARKER) && (flush_k == 3'd0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= NORM;
      expect_ts_q <= 1'b0;
      ts_hi_q     <= '0;
      ts_q        <= '0;
      ts_valid_q  <= 1'b0;
      ts_kind_q   <= 1'b0;
    end else begin
      ts_valid_q <= 1'b0;
      if (pkt_valid_i) begin
        case (state_q)
          NORM: begin
            if (alarm) begin
              ts_valid_q  <= 1'b1;
              ts_q        <= {1'b0, pkt_i[14:0], 16'h0000};
              ts_kind_q   <= 1'b0;
              expect_ts_q <= 1'b0;
            end else if (pkt_i[15] && (pkt_i == RES_MARKER)) begin
              state_q <= RES_HI;
            end else if (pkt_i[15]) begin
              expect_ts_q <= 1'b1;
            end
          end
          RES_HI: begin
            ts_hi_q <= pkt_i;
            state_q <= RES_LO;
          end
          RES_LO: begin
            ts_valid_q <= 1'b1;
            ts_q       <= {ts_hi_q, pkt_i};
            ts_kind_q  <= 1'b1;
            state_q    <= NORM;
          end
          default: state_q <= NORM;
        endcase
      end
    end
  end

  function automatic logic [2:0] triplet(input logic [14:0] p, input logic [2:0] idx);
    case (idx)
      3'd0:    triplet = p[2:0];
      3'd1:    triplet = p[5:3];
      3'd2:    triplet = p[8:6];
      3'd3:    triplet = p[11:9];
      3'd4:    triplet = p[14:12];
      default: triplet = 3'd0;
    endcase
  endfunction

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CW'(FIFO_DEPTH));
  assign idle   = (rem_q == 3'd0);
  assign pop    = idle && !empty;
  // An idle serializer with nothing queued takes the packet directly.
  assign bypass = idle && empty && push;
  assign wr     = push && !bypass && (!full || pop);
  assign drop   = push && !bypass && full && !pop;
  assign src    = pop ? mem_q[rd_q] : {push_cnt, pkt_i[14:0]};

  // rem_q counts pixels of ent_q still to be emitted, highest triplet first.
  always_comb begin
    ent_d = ent_q;
    rem_d = rem_q;
    pix_d = 3'd0;
    pv_d  = 1'b0;
    pl_d  = 1'b0;
    if (!idle) begin
      pix_d = triplet(ent_q, rem_q - 3'd1);
      rem_d = rem_q - 3'd1;
      pv_d  = 1'b1;
      pl_d  = (rem_q == 3'd1);
    end else if (pop || bypass) begin
      pix_d = triplet(src[14:0], src[17:15] - 3'd1);
      ent_d = src[14:0];
      rem_d = src[17:15] - 3'd1;
      pv_d  = 1'b1;
      pl_d  = (src[17:15] == 3'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr)
      mem_q[wr_q] <= {push_cnt, pkt_i[14:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      ent_q <= '0;
      rem_q <= 3'd0;
      pix_q <= 3'd0;
      pv_q  <= 1'b0;
      pl_q  <= 1'b0;
    end else begin
      if (wr)
        wr_q <= (wr_q == AW'(FIFO_DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (pop)
        rd_q <= (rd_q == AW'(FIFO_DEPTH - 1)) ? '0 : rd_q + 1'b1;
      case ({wr, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (drop)
        ovf_q <= 1'b1;
      ent_q <= ent_d;
      rem_q <= rem_d;
      pix_q <= pix_d;
      pv_q  <= pv_d;
      pl_q  <= pl_d;
    end
  end

  assign pix_o       = pix_q;
  assign pix_valid_o = pv_q;
  assign pix_last_o  = pl_q;
  assign ts_o        = ts_q;
  assign ts_valid_o  = ts_valid_q;
  assign ts_kind_o   = ts_kind_q;
  assign ovf_o       = ovf_q;

endmodule
`default_nettype wire

// File: doc/col_decoder_3b_plus.md
COL_DECODER_3B_PLUS -- requirements
Module: col_decoder_3b_plus

Interface
REQ-001 FIFO_DEPTH, 4, number of pixel-packet entries buffered ahead of the serializer.
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 pkt_in  input  16  encoded packet from the 3B+ column encoder.
REQ-005 pkt_valid  input  1  pkt_in valid this cycle; no backpressure exists, so a word is presented at most one cycle.
REQ-006 pix_out  output  3  decoded pixel value.
REQ-007 pix_valid  output  1  pix_out valid, at most one pixel per cycle.
REQ-008 pix_last  output  1  high with the final pixel of each packet.
REQ-009 ts_out  output  32  reconstructed timestamp.
REQ-010 ts_valid  output  1  one-cycle pulse qualifying ts_out.
REQ-011 ts_kind  output  1  0 = alarm timestamp, 1 = zero-run resurrection timestamp.
REQ-012 ovf  output  1  sticky flag set when an accepted-for-pixels packet is dropped because the FIFO is full.

Function
REQ-013 The parser SHALL have three states: NORM, RES_HI and RES_LO, plus a flag expect_ts.
REQ-014 Each parser action SHALL occur only in a cycle with pkt_valid=1.
REQ-015 In NORM, pkt_in[15]=0 SHALL be classified as raw: 5 pixels, payload bits [14:12],[11:9],[8:6],[5:3],[2:0], emitted in that order.
REQ-016 In NORM with expect_ts=1, a word with pkt_in[15]=1, including 16'h8000, SHALL be an alarm timestamp.
REQ-017 The alarm timestamp SHALL produce ts_out={1'b0,pkt_in[14:0],16'h0000} and ts_kind=0, and SHALL clear expect_ts.
REQ-018 In NORM with expect_ts=0, 16'h8000 SHALL be a resurrection marker and SHALL move the parser to RES_HI.
REQ-019 In NORM with expect_ts=0, any other word with bit15=1 SHALL be tested for flush markers, longest first, and set expect_ts=1 on a match.
REQ-020 Flush marker k=1 SHALL be [14:3]=12'hFFE, carrying 1 pixel in [2:0].
REQ-021 Flush marker k=2 SHALL be [14:6]=9'b111111110, carrying 2 pixels in [5:0].
REQ-022 Flush marker k=3 SHALL be [14:9]=6'b111110, carrying 3 pixels in [8:0].
REQ-023 Flush marker k=4 SHALL be [14:12]=3'b110, carrying 4 pixels in [11:0].
REQ-024 Flush pixels SHALL be emitted most significant triplet first.
REQ-025 A bit15=1 word in NORM with expect_ts=0 matching no flush marker SHALL be an alarm timestamp.
REQ-026 A raw packet with pkt_in[15]=0 SHALL leave expect_ts unchanged.
REQ-027 In RES_HI, the word SHALL be latched as ts_hi, whatever its value, and the parser SHALL move to RES_LO.
REQ-028 In RES_LO, the parser SHALL output ts_out={ts_hi,pkt_in} with ts_kind=1 and return to NORM.
REQ-029 Timestamp outputs SHALL be registered: ts_valid high exactly in cycle N+1 for a word accepted in cycle N.
REQ-030 Raw and flush packets SHALL be written as {count[2:0],payload[14:0]} into a FIFO of FIFO_DEPTH entries.
REQ-031 A FIFO write SHALL be allowed when not full, or when full and a pop occurs in the same cycle.
REQ-032 Otherwise the packet SHALL be dropped and ovf set to 1 until reset.
REQ-033 The serializer SHALL pop an entry when idle or on the cycle it emits its last pixel, giving gapless back-to-back output.
REQ-034 The serializer SHALL emit one pixel per cycle.
REQ-035 For a packet accepted in cycle N into an empty FIFO with an idle serializer, the first pix_valid SHALL occur in cycle N+1.
REQ-036 Pixel order SHALL equal packet acceptance order.
REQ-037 Timestamp pulses are not ordered against pixels still queued, and SHALL NOT stall the pixel path.
REQ-038 A packet whose pixels reached the FIFO SHALL never be lost.
REQ-039 A 5-pixel flush (no marker) is indistinguishable from a timestamp; it SHALL be decoded as an alarm timestamp, a documented limitation.

Reset
REQ-040 While rst_n=0, all outputs SHALL be 0.
REQ-041 While rst_n=0, the parser SHALL be in NORM with expect_ts=0 and ts_hi=0.
REQ-042 While rst_n=0, the FIFO and serializer SHALL be empty and ovf SHALL be 0.
REQ-043 Reset mid-packet SHALL discard all queued pixels and any partial resurrection with no further output.

Verification
REQ-044 Raw 16'h0A3B at cycle N -> pix_out 0,5,0,7,3 on cycles N+1..N+5, pix_last only at N+5, no ts_valid.
REQ-045 16'hFFAB then 16'h8123 -> pixels 5,3; ts_valid with ts_out=32'h01230000, ts_kind=0.
REQ-046 16'hFFAB then 16'h8000 -> pixels 5,3; ts_out=32'h00000000 with ts_kind=0, with no entry to RES_HI.
REQ-047 16'h8000,16'h1234,16'h5678 on consecutive cycles from reset -> single ts_valid with ts_out=32'h12345678, ts_kind=1, no pixels.
REQ-048 Raw packets valid on 10 consecutive cycles -> ovf=1; emitted pixels are gapless, in order, and only from whole accepted packets (multiple of 5, fewer than 50).
REQ-049 rst_n asserted during pixel drain -> pix_valid=0 immediately; no pixels after release until a new packet.
